mips_mem_stage: RTL and testbench

- Memory-access stage that sits directly downstream of the MIPS ALU in the EX→MEM→WB datapath.
- Consumes the ALU result as a data-memory address or as a pass-through value.
- Runs load/store transactions to data memory over a req/ack handshake with arbitrary wait states: byte-lane steering, sign/zero extension, misalignment detection.
- Hands a single registered result to writeback over a valid/ready handshake.

---
 rtl/mips_mem_stage.sv | 247 ++++++++++++++++++++++++
 tb/tb_mips_mem_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_stage.sv
// mips_mem_stage: MIPS memory-access stage between EX and WB.
//   Takes the ALU result either as a pass-through value or as a data-memory
//   address. Runs one load/store at a time over a req/ack handshake that may
//   take any number of wait states. Steers store bytes onto little-endian
//   lanes and extracts/extends load data. Flags misaligned half/word accesses
//   without touching memory. Holds one registered result for writeback.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               EX-side handshake
//   alu_result, store_data          address / pass-through value, rt value
//   mem_read, mem_write, mem_size   op kind (write wins), size 0/1/2(3=word)
//   load_unsigned, rd, reg_write    extension select, destination, wb enable
//   out_valid/out_ready             WB-side handshake
//   out_data, out_rd, out_reg_write result delivered to writeback
//   misalign_err                    one-cycle pulse on a misaligned access
//   dmem_req/we/addr/wdata/be       data-memory request (held until ack)
//   dmem_ack, dmem_rdata            data-memory completion and read data
module mips_mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              load_unsigned,
  input  logic [4:0]        rd,
  input  logic              reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              out_reg_write,
  output logic              misalign_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata
);

  typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t              state_r, state_s;
  logic                out_valid_r, out_valid_s;
  logic [DATA_W-1:0]   out_data_r, out_data_s;
  logic [4:0]          out_rd_r, out_rd_s;
  logic                out_reg_write_r, out_reg_write_s;
  logic                misalign_r, misalign_s;
  logic                dmem_req_r, dmem_req_s;
  logic                dmem_we_r, dmem_we_s;
  logic [ADDR_W-1:0]   dmem_addr_r, dmem_addr_s;
  logic [DATA_W-1:0]   dmem_wdata_r, dmem_wdata_s;
  logic [3:0]          dmem_be_r, dmem_be_s;
  // Op context kept while the memory transaction is outstanding.
  logic [ADDR_W-1:0]   op_alu_r, op_alu_s;
  logic [1:0]          op_size_r, op_size_s;
  logic                op_uns_r, op_uns_s;
  logic [4:0]          op_rd_r, op_rd_s;
  logic                op_rw_r, op_rw_s;

  logic                accept_s;
  logic                mem_op_s;
  logic [1:0]          size_s;
  logic                misalign_det_s;

  // Size code 3 behaves exactly like a word access.
  function automatic logic [1:0] eff_size(input logic [1:0] size);
    case (size)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] k);
    case (size)
      2'd0:    return 4'b0001 << k;
      2'd1:    return 4'b0011 << k;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the narrow value puts it on every lane; be selects the real one.
  function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0] size, input logic [DATA_W-1:0] d);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_format(input logic [1:0] size, input logic [1:0] k,
                                                    input logic uns, input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] sh;
    sh = rdata >> {k, 3'b000};
    case (size)
      2'd0:    return uns ? {{(DATA_W-8){1'b0}}, sh[7:0]}   : {{(DATA_W-8){sh[7]}}, sh[7:0]};
      2'd1:    return uns ? {{(DATA_W-16){1'b0}}, sh[15:0]} : {{(DATA_W-16){sh[15]}}, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  assign in_ready       = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s       = in_valid && in_ready;
  assign mem_op_s       = mem_read || mem_write;
  assign size_s         = eff_size(mem_size);
  assign misalign_det_s = ((size_s == 2'd1) && alu_result[0]) ||
                          ((size_s == 2'd2) && (alu_result[1:0] != 2'b00));

  // Next-state and next-output computation for the IDLE/REQ controller.
  always_comb begin
    state_s         = state_r;
    out_data_s      = out_data_r;
    out_rd_s        = out_rd_r;
    out_reg_write_s = out_reg_write_r;
    misalign_s      = 1'b0;
    dmem_req_s      = dmem_req_r;
    dmem_we_s       = dmem_we_r;
    dmem_addr_s     = dmem_addr_r;
    dmem_wdata_s    = dmem_wdata_r;
    dmem_be_s       = dmem_be_r;
    op_alu_s        = op_alu_r;
    op_size_s       = op_size_r;
    op_uns_s        = op_uns_r;
    op_rd_s         = op_rd_r;
    op_rw_s         = op_rw_r;
    if (out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (!mem_op_s) begin
            out_valid_s     = 1'b1;
            out_data_s      = alu_result;
            out_rd_s        = rd;
            out_reg_write_s = reg_write;
          end else if (misalign_det_s) begin
            // Fault: report it and hand the address on with writeback disabled.
            misalign_s      = 1'b1;
            out_valid_s     = 1'b1;
            out_data_s      = alu_result;
            out_rd_s        = rd;
            out_reg_write_s = 1'b0;
          end else begin
            state_s      = REQ;
            out_valid_s  = 1'b0;
            dmem_req_s   = 1'b1;
            dmem_we_s    = mem_write;
            dmem_addr_s  = {alu_result[ADDR_W-1:2], 2'b00};
            dmem_wdata_s = store_lanes(size_s, store_data);
            dmem_be_s    = mem_write ? store_be(size_s, alu_result[1:0]) : 4'b1111;
            op_alu_s     = alu_result;
            op_size_s    = size_s;
            op_uns_s     = load_unsigned;
            op_rd_s      = rd;
            op_rw_s      = reg_write;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_s     = IDLE;
          dmem_req_s  = 1'b0;
          out_valid_s = 1'b1;
          out_rd_s    = op_rd_r;
          if (dmem_we_r) begin
            out_data_s      = op_alu_r;
            out_reg_write_s = 1'b0;
          end else begin
            out_data_s      = load_format(op_size_r, op_alu_r[1:0], op_uns_r, dmem_rdata);
            out_reg_write_s = op_rw_r;
          end
        end else begin
          state_s = REQ;
        end
      end
      default: begin
        state_s    = IDLE;
        dmem_req_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      out_valid_r     <= 1'b0;
      out_data_r      <= {DATA_W{1'b0}};
      out_rd_r        <= 5'd0;
      out_reg_write_r <= 1'b0;
      misalign_r      <= 1'b0;
      dmem_req_r      <= 1'b0;
      dmem_we_r       <= 1'b0;
      dmem_addr_r     <= {ADDR_W{1'b0}};
      dmem_wdata_r    <= {DATA_W{1'b0}};
      dmem_be_r       <= 4'b0000;
      op_alu_r        <= {ADDR_W{1'b0}};
      op_size_r       <= 2'd0;
      op_uns_r        <= 1'b0;
      op_rd_r         <= 5'd0;
      op_rw_r         <= 1'b0;
    end else begin
      state_r         <= state_s;
      out_valid_r     <= out_valid_s;
      out_data_r      <= out_data_s;
      out_rd_r        <= out_rd_s;
      out_reg_write_r <= out_reg_write_s;
      misalign_r      <= misalign_s;
      dmem_req_r      <= dmem_req_s;
      dmem_we_r       <= dmem_we_s;
      dmem_addr_r     <= dmem_addr_s;
      dmem_wdata_r    <= dmem_wdata_s;
      dmem_be_r       <= dmem_be_s;
      op_alu_r        <= op_alu_s;
      op_size_r       <= op_size_s;
      op_uns_r        <= op_uns_s;
      op_rd_r         <= op_rd_s;
      op_rw_r         <= op_rw_s;
    end
  end

  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign out_rd        = out_rd_r;
  assign out_reg_write = out_reg_write_r;
  assign misalign_err  = misalign_r;
  assign dmem_req      = dmem_req_r;
  assign dmem_we       = dmem_we_r;
  assign dmem_addr     = dmem_addr_r;
  assign dmem_wdata    = dmem_wdata_r;
  assign dmem_be       = dmem_be_r;

endmodule

// File: tb/tb_mips_mem_stage.sv
// Testbench for mips_mem_stage: byte-addressed memory model plus a
// transaction-level reference of the stage, checked every cycle, with
// directed scenarios pinned by literal expectations and a random phase.
module tb_mips_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic        load_unsigned = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic        reg_write = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        misalign_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;

  mips_mem_stage #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .load_unsigned(load_unsigned),
    .rd(rd), .reg_write(reg_write), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .misalign_err(misalign_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state
  bit          m_busy = 1'b0, m_outv = 1'b0, m_err = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  logic        m_rw = 1'b0;
  bit          p_we = 1'b0, p_uns = 1'b0, p_rw = 1'b0;
  int          p_nb = 4;
  logic [31:0] p_alu = 32'd0, p_sd = 32'd0;
  logic [4:0]  p_rd = 5'd0;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0;
  logic        e_we = 1'b0;
  logic [3:0]  e_be = 4'd0;
  int          wcnt = 0, ack_wait = 0, m_acc_cnt = 0, req_cnt = 0;
  bit          spur_en = 1'b0, spur_force = 1'b0;
  logic [7:0]  ref_mem [int unsigned];
  logic [7:0]  phys_mem [int unsigned];

  function automatic logic [7:0] ref_b(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    else return 8'h00;
  endfunction

  function automatic logic [7:0] phys_b(input logic [31:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    else return 8'h00;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: one op at a time, results from a byte-addressed memory.
  initial begin : model
    bit acc, err_n;
    int nb;
    logic [31:0] v;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0; m_outv = 1'b0; m_err = 1'b0;
      end else begin
        err_n = 1'b0;
        acc = in_valid && !m_busy && (!m_outv || out_ready);
        if (m_busy) begin
          if (dmem_ack) begin
            if (dmem_we)
              for (int j = 0; j < 4; j++)
                if (dmem_be[j]) phys_mem[dmem_addr + j] = dmem_wdata[8*j +: 8];
            if (p_we) begin
              for (int i = 0; i < p_nb; i++) ref_mem[p_alu + i] = p_sd[8*i +: 8];
              m_data = p_alu; m_rw = 1'b0;
            end else begin
              v = 32'd0;
              for (int i = 0; i < p_nb; i++) v = v | (32'(ref_b(p_alu + i)) << (8*i));
              if (!p_uns && p_nb < 4 && v[8*p_nb-1]) v = v | ~((32'd1 << (8*p_nb)) - 32'd1);
              m_data = v; m_rw = p_rw;
            end
            m_rd = p_rd; m_outv = 1'b1; m_busy = 1'b0;
          end
        end else if (acc) begin
          m_acc_cnt++;
          nb = (mem_size == 2'd0) ? 1 : (mem_size == 2'd1) ? 2 : 4;
          if (!(mem_read || mem_write)) begin
            m_outv = 1'b1; m_data = alu_result; m_rd = rd; m_rw = reg_write;
          end else if ((alu_result % nb) != 0) begin
            m_outv = 1'b1; m_data = alu_result; m_rd = rd; m_rw = 1'b0; err_n = 1'b1;
          end else begin
            m_busy = 1'b1; m_outv = 1'b0; wcnt = ack_wait;
            p_we = mem_write; p_uns = load_unsigned; p_rw = reg_write; p_nb = nb;
            p_alu = alu_result; p_sd = store_data; p_rd = rd;
            e_addr = alu_result & 32'hFFFF_FFFC;
            e_we = mem_write;
            e_be = mem_write ? 4'(((1 << nb) - 1) << (alu_result % 4)) : 4'hF;
            e_wdata = (nb == 1) ? {4{store_data[7:0]}} :
                      (nb == 2) ? {2{store_data[15:0]}} : store_data;
          end
        end else if (out_ready) begin
          m_outv = 1'b0;
        end
        m_err = err_n;
      end
    end
  end

  // Memory responder: ack after wcnt waits, read data from physical memory.
  initial begin : responder
    forever begin
      @(posedge clk); #2;
      if (m_busy) begin
        if (wcnt == 0) dmem_ack = 1'b1;
        else begin dmem_ack = 1'b0; wcnt--; end
      end else begin
        dmem_ack = spur_force || (spur_en && $urandom_range(0, 3) == 0);
      end
      for (int j = 0; j < 4; j++) dmem_rdata[8*j +: 8] = phys_b(dmem_addr + j);
    end
  end

  // Every-cycle comparison against the reference.
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy && (!m_outv || out_ready)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_outv});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, m_busy});
      if (m_outv) begin
        chk("out_data", out_data, m_data);
        chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
        chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, m_rw});
      end
      if (m_busy) begin
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, e_we});
        chk("dmem_be", {28'd0, dmem_be}, {28'd0, e_be});
        if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
      end
      if (dmem_req) req_cnt++;
    end
  end

  task automatic issue(input bit rop, input bit wop, input logic [1:0] sz, input bit uns,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] r, input bit rw);
    int c0;
    int n;
    c0 = m_acc_cnt;
    mem_read = rop; mem_write = wop; mem_size = sz; load_unsigned = uns;
    alu_result = alu; store_data = sd; rd = r; reg_write = rw; in_valid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (m_acc_cnt == c0 && n < 50);
    in_valid = 1'b0;
    chk("accepted", {31'd0, m_acc_cnt != c0}, 32'd1);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin : stim
    int c0;
    int kind;
    phys_mem[32'h1000] = 8'hFF; phys_mem[32'h1001] = 8'hFF;
    phys_mem[32'h1002] = 8'hFF; phys_mem[32'h1003] = 8'h80;
    ref_mem[32'h1000] = 8'hFF; ref_mem[32'h1001] = 8'hFF;
    ref_mem[32'h1002] = 8'hFF; ref_mem[32'h1003] = 8'h80;

    // reset values
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_reg_write", {31'd0, out_reg_write}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // pass-through op, then back-to-back without bubbles
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_002A, 32'd0, 5'd5, 1'b1);
    @(negedge clk);
    chk("nonmem_valid", {31'd0, out_valid}, 32'd1);
    chk("nonmem_data", out_data, 32'h0000_002A);
    chk("nonmem_rd", {27'd0, out_rd}, 32'd5);
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_result = 32'h100 + i; rd = 5'(i + 1);
      c0 = m_acc_cnt;
      @(posedge clk); #1;
      chk("b2b_accept", m_acc_cnt - c0, 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last", out_data, 32'h0000_0103);
    @(posedge clk); #1;

    // lb at 0x1003 with 3 wait states, signed then unsigned
    ack_wait = 3; req_cnt = 0;
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 5'd7, 1'b1);
    @(negedge clk);
    chk("lb_addr", dmem_addr, 32'h0000_1000);
    @(posedge clk); #1;
    wait_out();
    @(negedge clk);
    chk("lb_req_cycles", req_cnt, 32'd4);
    chk("lb_signed", out_data, 32'hFFFF_FF80);
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 5'd7, 1'b1);
    wait_out();
    @(negedge clk);
    chk("lbu_data", out_data, 32'h0000_0080);
    @(posedge clk); #1;

    // sb at 0x2002
    ack_wait = 0;
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_2002, 32'h1234_56AB, 5'd8, 1'b1);
    @(negedge clk);
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_be", {28'd0, dmem_be}, 32'h4);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    @(posedge clk); #1;
    wait_out();
    @(negedge clk);
    chk("sb_reg_write", {31'd0, out_reg_write}, 32'd0);
    @(posedge clk); #1;

    // misaligned lw at 0x3002
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'd0, 5'd9, 1'b1);
    @(negedge clk);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_reg_write", {31'd0, out_reg_write}, 32'd0);
    chk("mis_data", out_data, 32'h0000_3002);
    @(negedge clk);
    chk("mis_pulse_end", {31'd0, misalign_err}, 32'd0);
    @(posedge clk); #1;

    // back-pressure from writeback
    out_ready = 1'b0;
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0055, 32'd0, 5'd3, 1'b1);
    alu_result = 32'h0000_0066; rd = 5'd4; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", out_data, 32'h0000_0055);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1 chk("bp_release", {31'd0, in_ready}, 32'd1);
    c0 = m_acc_cnt;
    @(posedge clk); #1;
    chk("bp_accept", m_acc_cnt - c0, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_new_data", out_data, 32'h0000_0066);
    @(posedge clk); #1;

    // reset while a request is outstanding
    ack_wait = 5;
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0, 5'd10, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    spur_force = 1'b1;
    @(posedge clk); #1;
    spur_force = 1'b0;
    @(negedge clk);
    chk("stray_ack_valid", {31'd0, out_valid}, 32'd0);
    chk("stray_ack_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    ack_wait = 1;
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'd0, 5'd11, 1'b1);
    wait_out();
    @(negedge clk);
    chk("post_rst_lw", out_data, 32'h80FF_FFFF);
    @(posedge clk); #1;

    // randomized traffic
    spur_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      ack_wait      = $urandom_range(0, 3);
      kind          = $urandom_range(0, 3);
      mem_read      = (kind == 1) || (kind == 3);
      mem_write     = (kind == 2) || (kind == 3);
      mem_size      = 2'($urandom_range(0, 3));
      load_unsigned = 1'($urandom_range(0, 1));
      rd            = 5'($urandom_range(0, 31));
      reg_write     = 1'($urandom_range(0, 1));
      store_data    = $urandom();
      alu_result    = (kind == 0) ? $urandom() : (32'h100 + 32'($urandom_range(0, 31)));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; spur_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
